// File: rtl/vec3_pack.sv
// rtl/vec3_pack.sv - packs a scalar word stream into 3-component vectors
module vec3_pack #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      din,
    input  logic                       in_empty,
    output logic                       in_rd_en,
    output logic [2:0][DATA_WIDTH-1:0] out,
    input  logic                       out_full,
    output logic                       out_wr_en,
    output logic [CNT_WIDTH-1:0]       vec_count,
    output logic                       busy
);

    typedef enum logic {
        LOAD  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:  if (!in_empty && idx == 2'd2) state_nxt = WRITE;
            WRITE: if (!out_full)                state_nxt = LOAD;
            default:                             state_nxt = LOAD;
        endcase
    end

    // Strobes are gated by reset so nothing is popped or pushed while it is held.
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        busy      = 1'b0;
        if (reset) begin
            in_rd_en  = (state == LOAD) && !in_empty;
            out_wr_en = (state == WRITE) && !out_full;
            busy      = ((state == LOAD) && (idx != 2'd0)) || (state == WRITE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx       <= 2'd0;
            out       <= '0;
            vec_count <= '0;
        end else begin
            if (in_rd_en) begin
                out[idx] <= din;
                idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
            if (out_wr_en) begin
                vec_count <= vec_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_vec3_pack.sv
// tb/tb_vec3_pack.sv - scoreboard bench for vec3_pack
module tb_vec3_pack;

    logic             clock;
    logic             reset;
    logic [31:0]      din;
    logic             in_empty;
    logic             in_rd_en;
    logic [2:0][31:0] out;
    logic             out_full;
    logic             out_wr_en;
    logic [1:0]       vec_count;
    logic             busy;

    vec3_pack #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out       (out),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .vec_count (vec_count),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] word_q[$];
    logic [31:0] bld[$];
    logic [95:0] exp_q[$];
    logic        gap      = 1'b0;
    logic        full     = 1'b0;
    logic        pop_flag = 1'b0;

    logic [2:0]       m_cnt  = 3'd0;
    logic [2:0][31:0] m_out  = '0;
    logic [1:0]       m_push = 2'd0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        word_q.push_back(w);
        bld.push_back(w);
        if (bld.size() == 3) begin
            exp_q.push_back({bld[2], bld[1], bld[0]});
            bld.delete();
        end
    endtask

    task automatic drive();
        in_empty = gap || (word_q.size() == 0);
        din      = in_empty ? $urandom : word_q[0];
        out_full = full;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (pop_flag && word_q.size() > 0) word_q.delete(0);
        pop_flag = 1'b0;
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (word_q.size() == 0 && m_cnt == 3'd0) break;
            step();
        end
        chk("wait_idle_timeout", (i < budget), 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        word_q.delete();
        bld.delete();
        exp_q.delete();
        drive();
        repeat (2) step();
        reset = 1'b1;
    endtask

    // Monitor: a vector model of lanes captured so far, checked every cycle.
    always @(negedge clock) begin
        logic exp_rd;
        logic exp_wr;
        if (!reset) begin
            chk("rst_in_rd_en", in_rd_en, 1'b0);
            chk("rst_out_wr_en", out_wr_en, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out", out, 96'd0);
            chk("rst_vec_count", vec_count, 2'd0);
            m_cnt    = 3'd0;
            m_out    = '0;
            m_push   = 2'd0;
            pop_flag = 1'b0;
        end else begin
            exp_rd = !in_empty && (m_cnt < 3'd3);
            exp_wr = (m_cnt == 3'd3) && !out_full;
            chk("in_rd_en", in_rd_en, exp_rd);
            chk("out_wr_en", out_wr_en, exp_wr);
            chk("busy", busy, m_cnt != 3'd0);
            chk("out_hold", out, m_out);
            chk("vec_count", vec_count, m_push);
            chk("rd_wr_exclusive", in_rd_en && out_wr_en, 1'b0);
            if (exp_wr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_push", 1'b1, 1'b0);
                end else begin
                    chk("push_data", out, exp_q.pop_front());
                end
                m_cnt  = 3'd0;
                m_push = m_push + 2'd1;
            end
            if (exp_rd) begin
                m_out[m_cnt[1:0]] = din;
                m_cnt = m_cnt + 3'd1;
            end
            pop_flag = in_rd_en;
        end
    end

    initial begin
        reset = 1'b0;
        drive();

        // Reset held with upstream words present.
        push_word(32'h0000_000A);
        push_word(32'h0000_000B);
        push_word(32'h0000_000C);
        drive();
        repeat (3) step();
        reset = 1'b1;
        wait_idle(50);

        // Streaming 1..6.
        for (int i = 1; i <= 6; i++) push_word(i);
        drive();
        wait_idle(50);

        // Gapped input.
        push_word(32'h0000_0400);
        drive();
        step();
        gap = 1'b1;
        drive();
        repeat (5) step();
        push_word(32'hFFFF_FC00);
        push_word(32'h0000_0800);
        gap = 1'b0;
        drive();
        wait_idle(50);

        // Backpressure after the third word, upstream still full.
        full = 1'b1;
        for (int i = 0; i < 6; i++) push_word(32'h1000_0000 + i);
        drive();
        repeat (3) step();
        repeat (6) step();
        full = 1'b0;
        drive();
        wait_idle(50);

        // Mid-vector reset discards the partial vector.
        push_word(32'hDEAD_0001);
        push_word(32'hDEAD_0002);
        drive();
        repeat (2) step();
        do_reset();
        push_word(32'd7);
        push_word(32'd8);
        push_word(32'd9);
        drive();
        wait_idle(50);

        // Reset while a complete vector is pending.
        full = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hBEEF_0000 + i);
        drive();
        repeat (4) step();
        full = 1'b0;
        do_reset();

        // Counter wrap: five vectors on a 2-bit counter.
        for (int i = 0; i < 15; i++) push_word($urandom);
        drive();
        wait_idle(100);
        @(negedge clock);
        chk("wrap_vec_count", vec_count, 2'd1);

        // Randomized traffic with gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3 == 0) && word_q.size() < 8) push_word($urandom);
            gap  = ($urandom % 4 == 0);
            full = ($urandom % 3 == 0);
            drive();
            step();
        end
        while (bld.size() != 0) push_word($urandom);
        gap  = 1'b0;
        full = 1'b0;
        drive();
        wait_idle(300);
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec3_pack.md
VEC3_PACK -- requirements
Module: vec3_pack

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of one vector component, treated as an opaque signed fixed-point word.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: width of the emitted-vector counter.
REQ-003 The block SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port din, input, DATA_WIDTH: head word of the upstream scalar FIFO, valid whenever in_empty=0.
REQ-006 The block SHALL have port in_empty, input, 1: upstream FIFO empty.
REQ-007 The block SHALL have port in_rd_en, output, 1: pops upstream head in the same cycle.
REQ-008 The block SHALL have port out, output, 3 x DATA_WIDTH (out[2:0]): assembled vector to the downstream FIFO.
REQ-009 The block SHALL have port out_full, input, 1: downstream FIFO full.
REQ-010 The block SHALL have port out_wr_en, output, 1: pushes out into the downstream FIFO this cycle.
REQ-011 The block SHALL have port vec_count, output, CNT_WIDTH: number of vectors pushed since reset.
REQ-012 The block SHALL have port busy, output, 1: high when at least one component of a vector has been captured and the vector is not yet pushed.

Function
REQ-013 The block SHALL implement the inverse of the vector-consuming math units: it converts a scalar word stream into 3-component vectors, with consecutive words mapping to out[0], out[1], out[2] in that order.
REQ-014 The block SHALL implement a state machine with states LOAD and WRITE, plus a 2-bit lane index idx in the range 0..2.
REQ-015 In LOAD with in_empty=0, the block SHALL drive in_rd_en=1 combinationally, capture din into out[idx] at the clock edge, and increment idx.
REQ-016 In LOAD when the word captured has idx=2, the block SHALL set idx to 0 and enter WRITE on the next cycle.
REQ-017 In LOAD with in_empty=1, the block SHALL keep in_rd_en=0 and leave state, idx and out unchanged.
REQ-018 In WRITE with out_full=0, the block SHALL drive out_wr_en=1 combinationally with out stable, increment vec_count, and return to LOAD.
REQ-019 In WRITE with out_full=1, the block SHALL keep out_wr_en=0 and hold out and state until out_full falls.
REQ-020 In WRITE the block SHALL keep in_rd_en=0 regardless of in_empty, so no word is popped while a vector is pending.
REQ-021 The block SHALL never assert in_rd_en and out_wr_en in the same cycle.
REQ-022 With both FIFOs unobstructed, the block SHALL have a throughput of 1 vector per 4 cycles: 3 pop cycles followed by 1 push cycle.
REQ-023 The block SHALL change out only on capture, so that out[k] holds its last written value until overwritten.
REQ-024 vec_count SHALL wrap modulo 2^CNT_WIDTH, from all-ones to 0, without any flag.
REQ-025 busy SHALL equal (state==LOAD && idx!=0) || state==WRITE.
REQ-026 The block SHALL pass data bit-exact, with no arithmetic, sign extension or truncation.

Reset
REQ-027 While reset=0, the block SHALL asynchronously force state=LOAD, idx=0, out[0..2]=0, vec_count=0, with in_rd_en, out_wr_en and busy all 0.
REQ-028 A reset asserted mid-vector (partial lanes captured or WRITE pending) SHALL discard the partial or pending vector, which is never pushed.
REQ-029 After reset deasserts, the first word popped SHALL land in out[0].

Verification
REQ-030 Reset check: hold reset=0 with in_empty=0 -> in_rd_en=0, out_wr_en=0, out all 0, vec_count=0.
REQ-031 Streaming: feed words 1,2,3,4,5,6 with in_empty=0 and out_full=0 -> pushes {1,2,3} at cycle 4 and {4,5,6} at cycle 8, then vec_count=2.
REQ-032 Gapped input: feed 0x400, then in_empty=1 for 5 cycles, then 0xFFFFFC00 and 0x800 -> a single push of {0x400,0xFFFFFC00,0x800} with busy=1 throughout the gap.
REQ-033 Backpressure: hold out_full=1 for 6 cycles after the third word -> out_wr_en=0 and in_rd_en=0 for those 6 cycles, then exactly one push, with upstream words still present afterwards.
REQ-034 Mid-vector reset: capture 2 words, pulse reset low, then feed 7,8,9 -> the only push is {7,8,9}.
REQ-035 Counter wrap: with CNT_WIDTH=2, push 5 vectors -> vec_count reads 1.
